// File: rtl/run_ctrl_if.sv
// Start/abort/PC inputs and status outputs between the run sequencer and its host.
// The host drives the master side; the sequencer uses the slave side.
interface run_ctrl_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [PC_W-1:0]  pc;
  logic             core_rst;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycles;

  modport master (
    output start, abort, pc,
    input  core_rst, busy, done, timeout, cycles
  );

  modport slave (
    input  start, abort, pc,
    output core_rst, busy, done, timeout, cycles
  );
endinterface

// File: rtl/run_ctrl.sv
// Run sequencer: turns a start edge into a clean core reset pulse, runs the core,
// and stops on the halt PC or a watchdog expiry, freezing the core until the next start.
module run_ctrl #(
  parameter int              PC_W    = 8,
  parameter logic [PC_W-1:0] DONE_PC = 8'hFF,
  parameter int              CNT_W   = 16,
  parameter int              RST_CYC = 2,
  parameter int              TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  run_ctrl_if.slave  bus
);

  localparam int               RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYC - 1);
  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_start_q;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [RC_W-1:0]  w_rst_cnt_nxt;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] w_cycles_nxt;
  logic             r_core_rst;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;

  logic             w_start_pe;
  logic             w_at_done;
  logic             w_wd_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign w_start_pe = bus.start & ~r_start_q;
  assign w_at_done  = (bus.pc == DONE_PC);
  assign w_wd_hit   = WD_EN && (r_cycles == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority: abort, then halt PC, then watchdog, then start edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = '0;
    w_cycles_nxt  = r_cycles;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (w_start_pe) begin
            w_state_nxt  = S_RESET;
            w_cycles_nxt = '0;
          end
        end
        S_RESET: begin
          if (r_rst_cnt == RC_LAST) begin
            w_state_nxt = S_RUN;
          end else begin
            w_rst_cnt_nxt = r_rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (w_at_done) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cycles_nxt = sat_inc(r_cycles);
            if (w_wd_hit) begin
              w_state_nxt = S_FAULT;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q  <= 1'b0;
      r_rst_cnt  <= '0;
      r_cycles   <= '0;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_start_q  <= bus.start;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_cycles   <= w_cycles_nxt;
      r_core_rst <= (w_state_nxt != S_RUN);
      r_busy     <= (w_state_nxt == S_RESET) || (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
      r_timeout  <= (w_state_nxt == S_FAULT);
    end
  end

  assign bus.core_rst = r_core_rst;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.timeout  = r_timeout;
  assign bus.cycles   = r_cycles;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed run scenarios push their expected end-of-run status
// into a queue; a monitor pops and compares each time busy drops.
module tb_run_ctrl;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  typedef struct {
    string            name;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycles;
  } exp_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  exp_t exp_q[$];

  run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  run_ctrl #(
    .PC_W    (PC_W),
    .DONE_PC (8'hFF),
    .CNT_W   (CNT_W),
    .RST_CYC (2),
    .TIMEOUT (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_end(input string name, input logic d, input logic t,
                            input logic [CNT_W-1:0] c);
    exp_t e;
    e.name = name; e.done = d; e.timeout = t; e.cycles = c;
    exp_q.push_back(e);
  endtask

  // Toggle start low then high, launch a run, pass the 2 RESET cycles, land in first RUN cycle.
  task automatic launch(input string name);
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    chk({name, "_rst0_core_rst"}, 32'(bus.core_rst), 1);
    chk({name, "_rst0_busy"},     32'(bus.busy), 1);
    chk({name, "_rst0_cycles"},   32'(bus.cycles), 0);
    tick();
    chk({name, "_rst1_core_rst"}, 32'(bus.core_rst), 1);
    tick();
    chk({name, "_run_core_rst"},  32'(bus.core_rst), 0);
  endtask

  // Monitor: every busy 1->0 transition ends a run and consumes one expectation.
  initial begin : monitor
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy === 1'b1 && bus.busy === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_run_end", 32'(bus.cycles), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_done"},     32'(bus.done), 32'(e.done));
          chk({e.name, "_timeout"},  32'(bus.timeout), 32'(e.timeout));
          chk({e.name, "_cycles"},   32'(bus.cycles), 32'(e.cycles));
          chk({e.name, "_core_rst"}, 32'(bus.core_rst), 1);
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin : stim
    n_pass  = 0;
    n_total = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pc    = '0;
    tick();
    tick();
    chk("reset_core_rst", 32'(bus.core_rst), 1);
    chk("reset_busy",     32'(bus.busy), 0);
    chk("reset_done",     32'(bus.done), 0);
    chk("reset_timeout",  32'(bus.timeout), 0);
    chk("reset_cycles",   32'(bus.cycles), 0);
    rst = 1'b0;

    // Normal completion after 10 counted RUN cycles
    launch("t1");
    repeat (10) tick();
    chk("t1_pre_cycles", 32'(bus.cycles), 10);
    bus.pc = 8'hFF;
    expect_end("t1", 1'b1, 1'b0, 16'd10);
    tick();
    bus.pc = 8'h00;
    chk("t1_done_core_rst", 32'(bus.core_rst), 1);

    // Restart from DONE; extra start pulse mid-run is ignored
    launch("t3");
    chk("t3_done_cleared", 32'(bus.done), 0);
    repeat (3) tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    chk("t4_no_restart_busy",   32'(bus.busy), 1);
    chk("t4_no_restart_cycles", 32'(bus.cycles), 5);
    repeat (5) tick();
    chk("t4_cycles_monotonic", 32'(bus.cycles), 10);
    bus.pc = 8'hFF;
    expect_end("t4", 1'b1, 1'b0, 16'd10);
    tick();
    bus.pc = 8'h00;

    // Abort at cycles=5
    launch("t5");
    repeat (5) tick();
    bus.abort = 1'b1;
    expect_end("t5", 1'b0, 1'b0, 16'd5);
    tick();
    bus.abort = 1'b0;
    chk("t5_idle_busy",   32'(bus.busy), 0);
    chk("t5_idle_cycles", 32'(bus.cycles), 5);

    // Watchdog at TIMEOUT=20
    launch("t2");
    expect_end("t2", 1'b0, 1'b1, 16'd20);
    repeat (19) tick();
    chk("t2_still_busy", 32'(bus.busy), 1);
    tick();
    chk("t2_fault_busy", 32'(bus.busy), 0);

    // Halt PC and watchdog in the same cycle: DONE wins, cycle not counted
    launch("t6");
    repeat (19) tick();
    bus.pc = 8'hFF;
    expect_end("t6", 1'b1, 1'b0, 16'd19);
    tick();
    bus.pc = 8'h00;

    // Reset mid-run, then start held high launches one run after reset
    launch("t7");
    repeat (4) tick();
    rst = 1'b1;
    expect_end("t7", 1'b0, 1'b0, 16'd0);
    tick();
    chk("t7_rst_core_rst", 32'(bus.core_rst), 1);
    chk("t7_rst_timeout",  32'(bus.timeout), 0);
    rst = 1'b0;
    tick();
    chk("t7_relaunch_busy", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    expect_end("t7b", 1'b0, 1'b0, 16'd0);
    tick();
    bus.abort = 1'b0;
    repeat (3) tick();
    chk("t7_no_second_run", 32'(bus.busy), 0);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
